// File: rtl/data_mem_mmio.sv
// Data-memory stage of the single-cycle MIPS core: a word RAM with combinational reads, plus a
// memory-mapped I/O block holding a GPIO register and a compare/reload timer with an interrupt.
module data_mem_mmio #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_gpio,
    output logic        o_irq,
    output logic        o_fault
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic [31:0] RamBytes = 32'(MEM_WORDS * 4);

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] gpio_q, gpio_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        irq_en_q, irq_en_d;
    logic        flag_q, flag_d;

    logic [31:0] io_off;
    logic        aligned, ram_sel, io_sel, wr_ok, match;
    logic        wr_gpio, wr_count, wr_cmp, wr_ctrl;
    logic [AW-1:0] ram_idx;

    // Address decode; the fault flag depends on the address alone, never on i_we.
    always_comb begin
        io_off   = i_addr - IO_BASE;
        aligned  = (i_addr[1:0] == 2'b00);
        ram_sel  = (i_addr < RamBytes);
        io_sel   = !ram_sel && (io_off < 32'd16);
        o_fault  = !aligned || !(ram_sel || io_sel);
        wr_ok    = i_we && !o_fault;
        ram_idx  = i_addr[AW+1:2];
        wr_gpio  = wr_ok && io_sel && (io_off[3:2] == 2'd0);
        wr_count = wr_ok && io_sel && (io_off[3:2] == 2'd1);
        wr_cmp   = wr_ok && io_sel && (io_off[3:2] == 2'd2);
        wr_ctrl  = wr_ok && io_sel && (io_off[3:2] == 2'd3);
    end

    always_comb begin
        o_rdata = 32'd0;
        if (!o_fault) begin
            if (ram_sel) begin
                o_rdata = mem[ram_idx];
            end else begin
                unique case (io_off[3:2])
                    2'd0: o_rdata = gpio_q;
                    2'd1: o_rdata = count_q;
                    2'd2: o_rdata = cmp_q;
                    2'd3: o_rdata = {23'd0, flag_q, 5'd0, irq_en_q, reload_q, en_q};
                endcase
            end
        end
    end

    // Match is evaluated on pre-edge COUNT/CMP/EN, so same-cycle stores cannot mask it.
    always_comb begin
        match    = (count_q == cmp_q);
        gpio_d   = wr_gpio ? i_wdata : gpio_q;
        cmp_d    = wr_cmp ? i_wdata : cmp_q;
        en_d     = wr_ctrl ? i_wdata[0] : en_q;
        reload_d = wr_ctrl ? i_wdata[1] : reload_q;
        irq_en_d = wr_ctrl ? i_wdata[2] : irq_en_q;

        count_d = count_q;
        if (wr_count) begin
            count_d = i_wdata;
        end else if (en_q && match) begin
            count_d = reload_q ? 32'd0 : count_q + 32'd1;
        end else if (en_q) begin
            count_d = count_q + 32'd1;
        end

        flag_d = flag_q;
        if (en_q && match) begin
            flag_d = 1'b1;
        end else if (wr_ctrl && i_wdata[8]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            gpio_q   <= 32'd0;
            count_q  <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            irq_en_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            irq_en_q <= irq_en_d;
            flag_q   <= flag_d;
        end
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok && ram_sel) begin
            mem[ram_idx] <= i_wdata;
        end
    end

    assign o_gpio = gpio_q;
    assign o_irq  = flag_q & irq_en_q;

endmodule
